pipeline_stage_regs: RTL

Pipeline-register bank for the five-stage MIPS core: holds the PC register, the IF/ID register and the ID/EX register. Applies the stall and flush commands issued by the hazard unit so that load-use and branch stalls hold the front end and inject bubbles into Execute. Also keeps saturating stall and bubble counters and a sticky protocol-error flag for bring-up.

---
 rtl/pipeline_stage_regs_pkg.sv | 14 +
 rtl/pipeline_stage_regs_sat_counter.sv | 13 +
 rtl/pipeline_stage_regs.sv | 84 ++++++++
 3 files changed

// File: rtl/pipeline_stage_regs_pkg.sv
// pipeline_stage_regs_pkg: shared widths, nop encoding and E-stage control bundle
package pipeline_stage_regs_pkg;
  localparam int DATA_W = 32;
  localparam int ALU_W = 3;
  localparam logic [31:0] NOP = 32'h0;
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic [ALU_W-1:0] alu_control;
  } ctrl_e_t;
endpackage

// File: rtl/pipeline_stage_regs_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: PC, IF/ID and ID/EX registers with hazard stall/flush handling
module pipeline_stage_regs
  import pipeline_stage_regs_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic [DW-1:0]    PCNextF,
  input  logic [DW-1:0]    InstrF,
  input  logic [DW-1:0]    PCPlus4F,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [ALU_W-1:0] ALUControlD,
  input  logic [DW-1:0]    RD1D,
  input  logic [DW-1:0]    RD2D,
  input  logic [DW-1:0]    SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic [DW-1:0]    PCF,
  output logic [DW-1:0]    InstrD,
  output logic [DW-1:0]    PCPlus4D,
  output logic             ValidD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [ALU_W-1:0] ALUControlE,
  output logic [DW-1:0]    RD1E,
  output logic [DW-1:0]    RD2E,
  output logic [DW-1:0]    SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt,
  output logic             proto_err
);
  ctrl_e_t ctrl_d, ctrl_e;
  assign ctrl_d = '{RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD};
  assign {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE} = ctrl_e;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) PCF <= RESET_PC;
    else if (!StallF) PCF <= PCNextF;
  // hold beats flush: a stalled decode slot must not lose its instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      InstrD <= DW'(NOP);
      PCPlus4D <= '0;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= FlushD ? DW'(NOP) : InstrF;
      PCPlus4D <= FlushD ? '0 : PCPlus4F;
      ValidD <= !FlushD;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || FlushE) begin
      ctrl_e <= '0;
      {RD1E, RD2E, SignImmE} <= '0;
      {RsE, RtE, RdE} <= '0;
      ValidE <= 1'b0;
    end else begin
      ctrl_e <= ctrl_d;
      {RD1E, RD2E, SignImmE} <= {RD1D, RD2D, SignImmD};
      {RsE, RtE, RdE} <= {RsD, RtD, RdD};
      ValidE <= ValidD;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) proto_err <= 1'b0;
    else if (StallF != StallD) proto_err <= 1'b1;
  sat_counter #(.W(32)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(StallD), .count(stall_cnt));
  sat_counter #(.W(32)) u_bubble_cnt (.clk(clk), .rst_n(rst_n), .en(FlushE), .count(bubble_cnt));
endmodule
